// File: rtl/alu_pkg.sv
// Shared ALU datapath types and sizing helpers for the pipelined CLA adder.
// Consumers import alu_pkg::* for the group width, flag bundle and slice sizing.
package alu_pkg;

    localparam int CLA_GROUP = 4;

    typedef struct packed {
        logic ovfl;
        logic zero;
        logic neg;
        logic cout;
    } alu_flags_t;

    function automatic int SLICE_W(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder: 4-bit lookahead groups whose
// group generate/propagate terms feed a second lookahead level for group carries.
module cla_slice
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);

    localparam int NG = W / CLA_GROUP;

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W-1:0]  c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '1;
        gc = '0;
        c  = '0;

        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < CLA_GROUP; i++) begin
                gg[j] = g[j*CLA_GROUP + i] | (p[j*CLA_GROUP + i] & gg[j]);
                gp[j] = gp[j] & p[j*CLA_GROUP + i];
            end
        end

        // Second level: group carries from group G/P only.
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end

        for (int j = 0; j < NG; j++) begin
            c[j*CLA_GROUP] = gc[j];
            for (int i = 0; i < CLA_GROUP - 1; i++) begin
                c[j*CLA_GROUP + i + 1] = g[j*CLA_GROUP + i] | (p[j*CLA_GROUP + i] & c[j*CLA_GROUP + i]);
            end
        end

        sum     = p ^ c;
        cout    = gc[NG];
        msb_cin = c[W-1];
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Bit-sliced pipelined CLA adder/subtractor, one WIDTH/STAGES slice per stage, with flags.
// Define PIPE_CLA_SAT_EN to saturate the sum on signed overflow; otherwise it wraps.
module pipelined_cla_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);

    // WIDTH must be a multiple of CLA_GROUP*STAGES.
    localparam int SW   = SLICE_W(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    logic adv;
    logic fire;

    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    alu_flags_t       flags_q;
    alu_flags_t       flags_d;

    logic             v_in [STAGES];
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];

    logic [SW-1:0] sl_sum  [STAGES];
    logic          sl_cout [STAGES];
    logic          sl_msbc [STAGES];

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign fire     = in_valid & adv;

    always_comb begin : stage_inputs
        v_in[0] = fire;
        a_in[0] = a;
        b_in[0] = sub ? ~b : b;
        s_in[0] = '0;
        c_in[0] = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(.W(SW)) u_slice (
            .a       (a_in[k][k*SW +: SW]),
            .b       (b_in[k][k*SW +: SW]),
            .cin     (c_in[k]),
            .sum     (sl_sum[k]),
            .cout    (sl_cout[k]),
            .msb_cin (sl_msbc[k])
        );
    end

    always_comb begin : stage_results
        logic [WIDTH-1:0] res;
        logic             ovf;
        for (int k = 0; k < STAGES; k++) begin
            s_d[k] = s_in[k];
            s_d[k][k*SW +: SW] = sl_sum[k];
        end
        // Carry into vs. out of the MSB differ exactly when same-sign operands give an opposite-sign sum.
        ovf = sl_cout[LAST] ^ sl_msbc[LAST];
        res = s_d[LAST];
`ifdef PIPE_CLA_SAT_EN
        if (ovf) begin
            res = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        s_d[LAST]     = res;
        flags_d.ovfl  = ovf;
        flags_d.zero  = ~|res;
        flags_d.neg   = res[WIDTH-1];
        flags_d.cout  = sl_cout[LAST];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            flags_q <= flags_d;
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_in[k];
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
                c_q[k] <= sl_cout[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = flags_q.cout;
    assign ovfl      = flags_q.ovfl;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;

endmodule
